// File: rtl/plane_pkg.sv
// Shared types and geometry constants for the player plane controller.
// PL/PH must stay in step with the renderer's wing/body extents (40x40).
package plane_pkg;

  localparam int SCR_W       = 640;
  localparam int SCR_H       = 480;
  localparam int PL          = 40;
  localparam int PH          = 40;
  localparam int STEP        = 4;
  localparam int HOME_X      = 20;
  localparam int HOME_Y      = 220;
  localparam int EXPL_FRAMES = 60;
  localparam int LIVES       = 3;
  localparam int COOLDOWN    = 8;

  // Sized copies so the datapath never mixes 32-bit ints with narrow registers.
  localparam logic [11:0] STEP_W        = 12'(STEP);
  localparam logic [11:0] MAX_X         = 12'(SCR_W - PL);
  localparam logic [11:0] MAX_Y         = 12'(SCR_H - PH);
  localparam logic [10:0] HOME_X_POS    = 11'(HOME_X);
  localparam logic [10:0] HOME_Y_POS    = 11'(HOME_Y);
  localparam logic [5:0]  EXPL_INIT     = 6'(EXPL_FRAMES);
  localparam logic [1:0]  LIVES_INIT    = 2'(LIVES);
  localparam logic [3:0]  COOLDOWN_INIT = 4'(COOLDOWN);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    EXPLODE = 2'd1,
    OVER    = 2'd2
  } state_t;

  // One frame of movement on a single axis. Both directions pressed cancel out.
  // Worked in 12 bits so the decrement can be tested against STEP before
  // subtracting and the increment can be clamped before narrowing.
  function automatic logic [10:0] axis_step(input logic [10:0] pos,
                                            input logic        dec,
                                            input logic        inc,
                                            input logic [11:0] max_pos);
    logic [11:0] wide;
    wide = {1'b0, pos};
    if (dec && !inc) begin
      if (wide < STEP_W) wide = 12'd0;
      else               wide = wide - STEP_W;
    end else if (inc && !dec) begin
      wide = wide + STEP_W;
      if (wide > max_pos) wide = max_pos;
    end
    return 11'(wide);
  endfunction

endpackage

// File: rtl/plane_ctrl_if.sv
// Button/collision inputs and renderer-facing outputs of the plane controller.
// master = debouncer/renderer side, slave = the controller itself.
interface plane_ctrl_if;

  logic        frame_tick;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_fire;
  logic        hit;
  logic [10:0] poX;
  logic [10:0] poY;
  logic        visible;
  logic        fire_pulse;
  logic [1:0]  lives;
  logic        game_over;

  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right, btn_fire, hit,
    input  poX, poY, visible, fire_pulse, lives, game_over
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right, btn_fire, hit,
    output poX, poY, visible, fire_pulse, lives, game_over
  );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced level input. The history register
// clears on reset, so a button held through reset reports an edge on the
// first cycle after reset is released.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev;

  // Remember last cycle's level of the button.
  always_ff @(posedge clk) begin
    if (!rst) prev <= 1'b0;
    else      prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/plane_ctrl.sv
// Per-frame player plane controller: movement with screen clamping, hit ->
// explosion blink -> respawn or game over, and rate-limited firing.
// Every output is a register so the renderer only sees changes during blanking.
module plane_ctrl
  import plane_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  plane_ctrl_if.slave  bus
);

  state_t      state, state_next;
  logic [10:0] pos_x, pos_x_next;
  logic [10:0] pos_y, pos_y_next;
  logic        vis, vis_next;
  logic        fire_q, fire_next;
  logic        over_q, over_next;
  logic [1:0]  lives_q, lives_next;
  logic [3:0]  cooldown, cooldown_next;
  logic [5:0]  counter, counter_next;
  logic [5:0]  counter_dec;
  logic        fire_rise;

  btn_edge u_fire_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_fire),
    .rise (fire_rise)
  );

  assign counter_dec = counter - 6'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= PLAY;
    else      state <= state_next;
  end

  // Position, visibility, lives, cooldown and explosion counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_x    <= HOME_X_POS;
      pos_y    <= HOME_Y_POS;
      vis      <= 1'b1;
      fire_q   <= 1'b0;
      over_q   <= 1'b0;
      lives_q  <= LIVES_INIT;
      cooldown <= 4'd0;
      counter  <= 6'd0;
    end else begin
      pos_x    <= pos_x_next;
      pos_y    <= pos_y_next;
      vis      <= vis_next;
      fire_q   <= fire_next;
      over_q   <= over_next;
      lives_q  <= lives_next;
      cooldown <= cooldown_next;
      counter  <= counter_next;
    end
  end

  // Next-state and next-output decode; a hit in PLAY overrides movement and fire.
  always_comb begin
    state_next    = state;
    pos_x_next    = pos_x;
    pos_y_next    = pos_y;
    vis_next      = vis;
    fire_next     = 1'b0;
    over_next     = over_q;
    lives_next    = lives_q;
    cooldown_next = cooldown;
    counter_next  = counter;

    case (state)
      PLAY: begin
        if (bus.hit) begin
          state_next   = EXPLODE;
          lives_next   = lives_q - 2'd1;
          counter_next = EXPL_INIT;
          vis_next     = EXPL_INIT[2];
        end else begin
          if (bus.frame_tick) begin
            pos_x_next = axis_step(pos_x, bus.btn_left, bus.btn_right, MAX_X);
            pos_y_next = axis_step(pos_y, bus.btn_up, bus.btn_down, MAX_Y);
            if (cooldown != 4'd0) cooldown_next = cooldown - 4'd1;
          end
          if (fire_rise && (cooldown == 4'd0)) begin
            fire_next     = 1'b1;
            cooldown_next = COOLDOWN_INIT;
          end
        end
      end

      EXPLODE: begin
        if (bus.frame_tick) begin
          counter_next = counter_dec;
          if (counter_dec == 6'd0) begin
            if (lives_q == 2'd0) begin
              state_next = OVER;
              vis_next   = 1'b0;
              over_next  = 1'b1;
            end else begin
              state_next    = PLAY;
              pos_x_next    = HOME_X_POS;
              pos_y_next    = HOME_Y_POS;
              vis_next      = 1'b1;
              cooldown_next = 4'd0;
            end
          end else begin
            vis_next = counter_dec[2];
          end
        end
      end

      OVER: begin
        vis_next  = 1'b0;
        over_next = 1'b1;
        if (fire_rise) begin
          state_next    = PLAY;
          lives_next    = LIVES_INIT;
          pos_x_next    = HOME_X_POS;
          pos_y_next    = HOME_Y_POS;
          vis_next      = 1'b1;
          over_next     = 1'b0;
          cooldown_next = 4'd0;
        end
      end

      default: begin
        state_next = PLAY;
      end
    endcase
  end

  assign bus.poX        = pos_x;
  assign bus.poY        = pos_y;
  assign bus.visible    = vis;
  assign bus.fire_pulse = fire_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = over_q;

endmodule
